// File: rtl/msk_pkg.sv
// Shared definitions for the sequential share-recombination datapath:
// FSM encoding, counter sizing and the share slice layout (i*W+b).
package msk_pkg;

  localparam int DEFAULT_SHARES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    HOLD = 2'd2
  } msk_state_t;

  // Fold counter width: $clog2(shares), never narrower than one bit.
  function automatic int cnt_width(input int shares);
    return (shares < 2) ? 1 : $clog2(shares);
  endfunction

  // LSB position of share i in a flattened sharing (bit b lives at i*w+b).
  function automatic int share_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/msk_share_shreg.sv
// Holds the not-yet-folded shares; shifts down one share per fold with
// zero fill so consumed shares never linger in the register.
module msk_share_shreg
  import msk_pkg::*;
#(
  parameter int N_SH = 1,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [N_SH*W-1:0] load_data,
  output logic [W-1:0]      sh0
);

  logic [N_SH*W-1:0] sh_q;

  // Share register: clear beats load beats shift; top share refills with 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else if (clear) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= load_data;
    end else if (shift) begin
      sh_q <= sh_q >> W;
    end
  end

  assign sh0 = sh_q[share_lsb(0, W) +: W];

endmodule

// File: rtl/msk_unmask_seq.sv
// Sequential unmasking: accepts one d-share sharing, XOR-folds one share
// per cycle into a register accumulator and offers the recombined word on
// a valid/ready output. Only a single W-bit XOR sits between registers.
module msk_unmask_seq
  import msk_pkg::*;
#(
  parameter int d = DEFAULT_SHARES,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [d*W-1:0] in_sh,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int                CNT_W    = cnt_width(d);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(d - 2);

  msk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     sh0;
  logic             accept;
  logic             fold;
  logic             hs_out;

  // Share 0 goes straight into the accumulator, so only shares 1..d-1 are stored.
  assign accept = (state_q == IDLE) && in_valid;
  assign fold   = (state_q == FOLD);
  assign hs_out = (state_q == HOLD) && out_ready;

  msk_share_shreg #(
    .N_SH (d - 1),
    .W    (W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (fold),
    .clear     (hs_out),
    .load_data (in_sh[share_lsb(1, W) +: (d - 1) * W]),
    .sh0       (sh0)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fold d-1 times, then hold until the consumer takes the word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = FOLD;
      FOLD:    if (cnt_q == LAST_CNT) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator and fold counter; acc is wiped once the word is delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= in_sh[share_lsb(0, W) +: W];
      cnt_q <= '0;
    end else if (fold) begin
      acc_q <= acc_q ^ sh0;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (hs_out) begin
      acc_q <= '0;
    end
  end

  // Handshake outputs; out_data is forced to zero whenever it is not valid.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        out_data  = acc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msk_unmask_seq.sv
// Bench for msk_unmask_seq: three instances (d=2,3,4, W=8) share one clock,
// reset and input bus; each has its own valid/ready. Directed table vectors,
// hand-written corner sequences and a random run against a timestamp model.
module tb_msk_unmask_seq;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_sh;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [7:0]  out_data [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msk_unmask_seq #(.d(2), .W(W)) u_d2 (
    .clk(clk), .rst(rst), .in_sh(in_sh[15:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]));

  msk_unmask_seq #(.d(3), .W(W)) u_d3 (
    .clk(clk), .rst(rst), .in_sh(in_sh[23:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]));

  msk_unmask_seq #(.d(4), .W(W)) u_d4 (
    .clk(clk), .rst(rst), .in_sh(in_sh[31:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]));

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge (sample/drive point).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Recombined word: XOR of the first dd shares of a sharing.
  function automatic logic [7:0] xor_shares(input logic [31:0] sh, input int dd);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < dd; i++) w ^= sh[i*8 +: 8];
    return w;
  endfunction

  // One full transaction on instance k. The accept edge counts as the first
  // of d edges, so after it d-1 further edges pass before out_valid shows.
  task automatic run_word(input int k, input int dd, input logic [31:0] sh,
                          input logic [7:0] exp, input string nm);
    int lat;
    chk({nm, "_rdy_idle"}, 32'(in_ready[k]), 1);
    in_sh       = sh;
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b0;
    tick();
    in_valid[k] = 1'b0;
    in_sh       = $urandom;
    lat = 0;
    while (!out_valid[k] && lat < 10) begin
      chk({nm, "_rdy_busy"}, 32'(in_ready[k]), 0);
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(dd - 1));
    chk({nm, "_data"}, 32'(out_data[k]), 32'(exp));
    chk({nm, "_rdy_hold"}, 32'(in_ready[k]), 0);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({nm, "_ov_after"}, 32'(out_valid[k]), 0);
    chk({nm, "_od_after"}, 32'(out_data[k]), 0);
    chk({nm, "_rdy_after"}, 32'(in_ready[k]), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl [6];
    int         n_acc, n07, n77, last, seen;
    logic       acc_now;
    logic [7:0] q [$];
    int         dv [3];
    bit         busy [3];
    int         acc_edge [3];
    logic [7:0] word [3];
    bit         exp_ov [3];
    int         edge_n;

    tbl[0] = '{8'h5A, 8'h3C, 8'h11, 8'h77};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{8'h01, 8'h02, 8'h04, 8'h07};
    tbl[4] = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    tbl[5] = '{8'h80, 8'h80, 8'h01, 8'h01};
    dv = '{2, 3, 4};

    rst       = 1'b1;
    in_sh     = '0;
    in_valid  = '0;
    out_ready = '0;
    #1;
    chk("reset_ov", 32'(out_valid), 0);
    chk("reset_od3", 32'(out_data[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_rdy", 32'(in_ready), 32'h7);
    chk("reset_shreg3", 32'(u_d3.u_shreg.sh_q), 0);

    // Directed vectors on d=3; in_sh is scrambled right after each accept.
    foreach (tbl[i]) begin
      run_word(1, 3, {8'h00, tbl[i].s2, tbl[i].s1, tbl[i].s0}, tbl[i].exp,
               $sformatf("tbl%0d", i));
    end

    // d=2, 0xFF^0xFF held under backpressure for 10 cycles.
    in_sh = 32'h0000FFFF;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_ov", 32'(out_valid[0]), 1);
      chk("bp_od", 32'(out_data[0]), 0);
      chk("bp_rdy", 32'(in_ready[0]), 0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp_idle_rdy", 32'(in_ready[0]), 1);
    chk("bp_idle_ov", 32'(out_valid[0]), 0);

    // d=3, second sharing held on the bus during word 1: ignored until IDLE.
    in_sh = 32'h00113C5A;
    in_valid[1] = 1'b1;
    tick();
    in_sh = 32'h00040201;
    for (int i = 0; i < 5; i++) begin
      chk("ovl_rdy_busy", 32'(in_ready[1]), 0);
      tick();
    end
    chk("ovl_w1_ov", 32'(out_valid[1]), 1);
    chk("ovl_w1_data", 32'(out_data[1]), 32'h77);
    out_ready[1] = 1'b1;
    n_acc = 0; n07 = 0; n77 = 0;
    for (int i = 0; i < 12; i++) begin
      acc_now = in_ready[1] & in_valid[1];
      tick();
      if (acc_now) begin
        in_valid[1] = 1'b0;
        n_acc++;
      end
      if (out_valid[1] && out_data[1] == 8'h07) n07++;
      if (out_valid[1] && out_data[1] == 8'h77) n77++;
    end
    out_ready[1] = 1'b0;
    chk("ovl_accepts", 32'(n_acc), 1);
    chk("ovl_w2_once", 32'(n07), 1);
    chk("ovl_w1_once", 32'(n77), 0);

    // d=4, asynchronous reset in the middle of a fold discards the word.
    in_sh = 32'h04030201;
    in_valid[2] = 1'b1;
    tick();
    in_valid[2] = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_od4", 32'(out_data[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_rdy", 32'(in_ready[2]), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[2]) seen++;
      tick();
    end
    chk("arst_no_emit", 32'(seen), 0);
    run_word(2, 4, 32'h80402010, 8'hF0, "arst_next");

    // d=3 back-to-back with a consumer that is always ready.
    in_sh = $urandom;
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b1;
    last = -1;
    q.delete();
    for (int i = 0; i < 24; i++) begin
      if (out_valid[1]) begin
        chk("b2b_shreg_zero", 32'(u_d3.u_shreg.sh_q), 0);
        if (q.size() > 0) chk("b2b_data", 32'(out_data[1]), 32'(q.pop_front()));
        else chk("b2b_spurious", 32'(out_valid[1]), 0);
      end
      if (in_ready[1] & in_valid[1]) begin
        if (last >= 0) chk("b2b_interval", 32'(i - last), 4);
        last = i;
        q.push_back(xor_shares(in_sh, 3));
      end
      tick();
      in_sh = $urandom;
    end
    in_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    out_ready[1] = 1'b0;
    chk("b2b_drained_rdy", 32'(in_ready[1]), 1);

    // Random run on all three instances against a timestamp model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    for (int k = 0; k < 3; k++) begin
      busy[k] = 1'b0;
      acc_edge[k] = 0;
      word[k] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        exp_ov[k] = busy[k] && (edge_n - acc_edge[k] >= dv[k] - 1);
        chk($sformatf("rnd_rdy_d%0d", dv[k]), 32'(in_ready[k]), 32'(!busy[k]));
        chk($sformatf("rnd_ov_d%0d", dv[k]), 32'(out_valid[k]), 32'(exp_ov[k]));
        chk($sformatf("rnd_od_d%0d", dv[k]), 32'(out_data[k]),
            exp_ov[k] ? 32'(word[k]) : 32'h0);
      end
      if (exp_ov[1]) chk("rnd_shreg_zero", 32'(u_d3.u_shreg.sh_q), 0);
      in_sh = $urandom;
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 2) != 0);
      end
      for (int k = 0; k < 3; k++) begin
        if (exp_ov[k] && out_ready[k]) begin
          busy[k] = 1'b0;
        end else if (!busy[k] && in_valid[k]) begin
          busy[k] = 1'b1;
          acc_edge[k] = edge_n + 1;
          word[k] = xor_shares(in_sh, dv[k]);
        end
      end
      tick();
      edge_n++;
    end
    in_valid  = '0;
    out_ready = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
